// File: rtl/project_mem_copy_master.sv
// Avalon-MM block copy/fill master for a word-addressed on-chip memory. Optional checksum port: MEMCOPY_CHECKSUM_EN.
// Registered bus outputs; COPY costs 2+READ_LATENCY cycles per word, FILL one; pause freezes the engine and the memory.
`timescale 1ns/1ps
module project_mem_copy_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 15,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic [DATA_W-1:0]   fill_value,
    input  logic                pause,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    output logic                clken
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

    state_t              state, state_n;
    logic [1:0]          wait_cnt, wait_cnt_n;
    logic [ADDR_W-1:0]   src_ptr, src_n, dst_ptr, dst_n;
    logic [LEN_W-1:0]    remain, remain_n;
    logic                mode_q, mode_n;
    logic [DATA_W-1:0]   fill_q, fill_n, hold_q, hold_n;
    logic                busy_n, done_n, cs_n, wr_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [BE_W-1:0]     be_n;

    assign clken = ~pause;

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        src_n      = src_ptr;
        dst_n      = dst_ptr;
        remain_n   = remain;
        mode_n     = mode_q;
        fill_n     = fill_q;
        hold_n     = hold_q;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_n   = mode;
                    src_n    = src_addr;
                    dst_n    = dst_addr;
                    remain_n = length;
                    fill_n   = fill_value;
                    if (length == '0)
                        state_n = FIN;
                    else if (mode)
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD: begin
                state_n    = WAIT;
                wait_cnt_n = WAIT_INIT;
            end
            WAIT: begin
                // readdata is valid exactly on the last WAIT cycle
                if (wait_cnt == 2'd0) begin
                    hold_n  = readdata;
                    state_n = WR;
                end else begin
                    wait_cnt_n = wait_cnt - 2'd1;
                end
            end
            WR: begin
                src_n    = src_ptr + ADDR_W'(1);
                dst_n    = dst_ptr + ADDR_W'(1);
                remain_n = remain - LEN_W'(1);
                if (remain == LEN_W'(1))
                    state_n = FIN;
                else if (mode_q)
                    state_n = WR;
                else
                    state_n = RD;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they leave a flop.
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = address;
        wdata_n = writedata;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_n)
            RD: begin
                cs_n   = 1'b1;
                addr_n = src_n;
                busy_n = 1'b1;
            end
            WAIT: busy_n = 1'b1;
            WR: begin
                cs_n    = 1'b1;
                wr_n    = 1'b1;
                addr_n  = dst_n;
                wdata_n = mode_n ? fill_n : hold_n;
                busy_n  = 1'b1;
            end
            FIN:     done_n = 1'b1;
            default: ;
        endcase
        be_n = cs_n ? '1 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remain     <= '0;
            mode_q     <= 1'b0;
            fill_q     <= '0;
            hold_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
        end else if (pause) begin
            // a done already shown must not stretch while frozen
            done <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            src_ptr    <= src_n;
            dst_ptr    <= dst_n;
            remain     <= remain_n;
            mode_q     <= mode_n;
            fill_q     <= fill_n;
            hold_q     <= hold_n;
            busy       <= busy_n;
            done       <= done_n;
            address    <= addr_n;
            byteenable <= be_n;
            chipselect <= cs_n;
            write      <= wr_n;
            writedata  <= wdata_n;
        end
    end

`ifdef MEMCOPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (!pause) begin
            if (state == IDLE && start)
                checksum <= '0;
            else if (state == WR)
                checksum <= checksum + writedata;
        end
    end
`endif

endmodule

// File: tb/tb_project_mem_copy_master.sv
// Bench for project_mem_copy_master: directed test-plan cases plus random COPY/FILL operations
// against a per-cycle expected bus trace and a shadow memory image.
`timescale 1ns/1ps
module tb_project_mem_copy_master;
    localparam int AW = 14, DW = 32, LW = 15, RL = 1, DEPTH = 1 << AW;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, pause = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] fill_value = '0;
    logic busy, done, chipselect, write, clken;
    logic [AW-1:0] address;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    project_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .pause(pause), .busy(busy), .done(done),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata), .clken(clken)
`ifdef MEMCOPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Memory slave: one-cycle synchronous read, frozen when clken is low.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    always @(posedge clk) begin
        if (clken) begin
            if (chipselect && write) ram[address] <= writedata;
            else if (chipselect)     readdata <= ram[address];
        end
    end

    typedef struct packed {
        logic cs; logic wr; logic busy; logic done;
        logic [AW-1:0] addr; logic [DW-1:0] data;
    } exp_t;
    localparam exp_t IDLE_E = '0;

    exp_t q[$];
    exp_t cur = '0;
    int checks = 0, errors = 0, busy_cycles = 0;
    logic p_edge = 1'b0;
    logic [DW-1:0] model_sum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected per-cycle trace of one operation, read from the shadow image as it will stand.
    task automatic gen(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [LW-1:0] n, input logic [DW-1:0] f);
        logic [DW-1:0] ov [int];
        exp_t e;
        logic [AW-1:0] sa, da;
        logic [DW-1:0] v;
        model_sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            if (m) v = f;
            else begin
                v = ov.exists(int'(sa)) ? ov[int'(sa)] : shadow[sa];
                e = '0; e.cs = 1'b1; e.busy = 1'b1; e.addr = sa; q.push_back(e);
                for (int w = 0; w < RL; w++) begin
                    e = '0; e.busy = 1'b1; q.push_back(e);
                end
            end
            e = '0; e.cs = 1'b1; e.wr = 1'b1; e.busy = 1'b1; e.addr = da; e.data = v;
            q.push_back(e);
            ov[int'(da)] = v;
            model_sum += v;
        end
        e = '0; e.done = 1'b1; q.push_back(e);
    endtask

    always @(posedge clk) p_edge = pause;

    always @(negedge clk) begin
        logic nclk;
        if (reset) cur = IDLE_E;
        else if (!p_edge) begin
            cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            if (cur.cs && cur.wr) shadow[cur.addr] = cur.data;
        end else cur.done = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        nclk = !pause;
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("chipselect", 32'(chipselect), 32'(cur.cs));
        chk("write", 32'(write), 32'(cur.wr));
        chk("byteenable", 32'(byteenable), cur.cs ? 32'hF : 32'h0);
        chk("clken", 32'(clken), 32'(nclk));
        if (cur.cs) chk("address", 32'(address), 32'(cur.addr));
        if (cur.cs && cur.wr) chk("writedata", writedata, cur.data);
    end

    task automatic mem_cmp();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== shadow[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);
    endtask

    task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input logic [DW-1:0] f,
                          input int p_at, input int p_len, input int intr_at, input int busy_exp);
        bit ended = 1'b0;
        @(posedge clk); #1;
        busy_cycles = 0;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
        @(negedge clk); #1;
        gen(m, s, d, n, f);
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
        length = LW'($urandom); fill_value = $urandom;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (p_at > 0 && cyc == p_at) pause = 1'b1;
            if (p_at > 0 && cyc == p_at + p_len) pause = 1'b0;
            start = (cyc == intr_at) && (q.size() > 0);
            if (q.size() == 0 && !pause && cyc > 1) begin
                ended = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        pause = 1'b0;
        chk("op_end", 32'(ended), 32'd1);
        mem_cmp();
        if (busy_exp >= 0) chk("busy_cycles", 32'(busy_cycles), 32'(busy_exp));
`ifdef MEMCOPY_CHECKSUM_EN
        chk("checksum", checksum, model_sum);
`endif
    endtask

    initial begin
        logic [DW-1:0] v500, pre701;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            shadow[i] = ram[i];
        end
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
        shadow[0] = 32'h11; shadow[1] = 32'h22; shadow[2] = 32'h33;

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cs", 32'(chipselect), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_byteenable", 32'(byteenable), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op(1'b1, 14'h0, 14'h0100, 15'd4, 32'hDEADBEEF, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) chk("fill_mem", ram[14'h100 + AW'(i)], 32'hDEADBEEF);

        run_op(1'b0, 14'h0, 14'h0200, 15'd3, 32'h0, 0, 0, 0, 9);
        chk("copy_mem0", ram[14'h200], 32'h11);
        chk("copy_mem1", ram[14'h201], 32'h22);
        chk("copy_mem2", ram[14'h202], 32'h33);
`ifdef MEMCOPY_CHECKSUM_EN
        chk("copy_checksum", checksum, 32'h66);
`endif

        run_op(1'b1, 14'h0, 14'h3FFE, 15'd4, 32'hA5A50001, 0, 0, 0, 4);
        chk("wrap_3ffe", ram[14'h3FFE], 32'hA5A50001);
        chk("wrap_3fff", ram[14'h3FFF], 32'hA5A50001);
        chk("wrap_0000", ram[14'h0000], 32'hA5A50001);
        chk("wrap_0001", ram[14'h0001], 32'hA5A50001);

        run_op(1'b0, 14'h0010, 14'h0020, 15'd0, 32'h0, 0, 0, 0, 0);
        run_op(1'b0, 14'h0010, 14'h0300, 15'd5, 32'h0, 0, 0, 4, 15);

        run_op(1'b0, 14'h0000, 14'h0400, 15'd2, 32'h0, 2, 5, 0, 11);
        chk("pause_mem0", ram[14'h400], 32'hA5A50001);
        chk("pause_mem1", ram[14'h401], 32'hA5A50001);

        v500 = ram[14'h500];
        run_op(1'b0, 14'h0500, 14'h0501, 15'd4, 32'h0, 0, 0, 0, 12);
        chk("overlap_504", ram[14'h504], v500);
        run_op(1'b0, 14'h0600, 14'h0600, 15'd3, 32'h0, 0, 0, 0, 9);

        pre701 = ram[14'h701];
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; src_addr = 14'h600; dst_addr = 14'h700; length = 15'd4;
        @(negedge clk); #1;
        gen(1'b0, 14'h600, 14'h700, 15'd4, 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cs", 32'(chipselect), 32'd0);
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_address", 32'(address), 32'd0);
        chk("mid_rst_writedata", writedata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        mem_cmp();
        chk("rst_word1", ram[14'h700], ram[14'h600]);
        chk("rst_word2", ram[14'h701], pre701);

        for (int k = 0; k < 40; k++) begin
            int n, pa, pl, ia;
            n  = $urandom_range(0, 24);
            pa = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n * 2) : 0;
            pl = $urandom_range(1, 4);
            ia = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            run_op(1'($urandom), AW'($urandom), AW'($urandom), LW'(n), $urandom, pa, pl, ia, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
